pic_interrupt_core: RTL and testbench

//  Synchronous, parametrised interrupt core for the PIC: request capture (IRR), priority resolution, in-service tracking (ISR).

---
 rtl/pic_pkg.sv | 29 ++
 rtl/pic_priority_resolver.sv | 31 +++
 rtl/pic_interrupt_core.sv | 164 ++++++++++++++++
 tb/tb_pic_interrupt_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and priority helpers for the PIC interrupt core.
// Priority is cyclic: the ID just above lowest_prio ranks highest (rank 0).
package pic_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK1 = 1'b1
   } pic_state_e;

   // ID returned when INTA arrives with no eligible request
   function automatic int unsigned spurious_id(input int unsigned n);
      return n - 1;
   endfunction

   // ID holding rank k (k = 0 is the highest priority)
   function automatic int unsigned prio_idx(input int unsigned lowest,
                                            input int unsigned k,
                                            input int unsigned n);
      return (lowest + 1 + k) % n;
   endfunction

   // rank of an ID; smaller rank means higher priority
   function automatic int unsigned prio_rank(input int unsigned id,
                                             input int unsigned lowest,
                                             input int unsigned n);
      return (id + n - lowest - 1) % n;
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational cyclic priority encoder: picks the highest-ranked set bit of req
// given the current lowest-priority ID.
module pic_priority_resolver
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [ID_W-1:0]    lowest_prio,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   logic [ID_W-1:0] idx;

   // scan from lowest rank upward so the highest-ranked hit is written last
   always_comb begin
      valid = 1'b0;
      id    = '0;
      idx   = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         idx = ID_W'(prio_idx(32'(lowest_prio), k, NUM_IRQ));
         if (req[idx]) begin
            valid = 1'b1;
            id    = idx;
         end
      end
   end

endmodule

// File: rtl/pic_interrupt_core.sv
// PIC interrupt core: IRR capture, cyclic priority, ISR nesting, two-pulse INTA, EOI/AEOI.
// Optional macro PIC_SPECIAL_MASK_EN adds smm_i (special mask mode).
//
// state | meaning
// IDLE  | waiting for first INTA pulse
// ACK1  | winner frozen in ack_id, waiting for second INTA pulse
module pic_interrupt_core
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] mask_i,
   input  logic               level_mode_i,
   input  logic               rotate_mode_i,
   input  logic               aeoi_i,
   input  logic               inta_i,
   input  logic               eoi_valid_i,
   input  logic               eoi_specific_i,
   input  logic               eoi_rotate_i,
   input  logic [ID_W-1:0]    eoi_id_i,
`ifdef PIC_SPECIAL_MASK_EN
   input  logic               smm_i,
`endif
   output logic               int_o,
   output logic               vector_valid_o,
   output logic [ID_W-1:0]    vector_o,
   output logic [NUM_IRQ-1:0] irr_o,
   output logic [NUM_IRQ-1:0] isr_o
);

   pic_state_e         state, state_nxt;
   logic               ack_start, ack_end;
   logic [NUM_IRQ-1:0] irr, irr_nxt;
   logic [NUM_IRQ-1:0] isr, isr_nxt, isr_arb;
   logic [NUM_IRQ-1:0] irq_q;
   logic [ID_W-1:0]    lowest_prio, lowest_nxt;
   logic [ID_W-1:0]    ack_id;
   logic               ack_spur;
   logic               win_valid, isr_valid;
   logic [ID_W-1:0]    win_id, isr_id;
   logic               eoi_hit;
   logic [ID_W-1:0]    eoi_target;
   logic               int_nxt;

`ifdef PIC_SPECIAL_MASK_EN
   // masked in-service levels stop blocking lower-priority requests
   assign isr_arb = smm_i ? (isr & ~mask_i) : isr;
`else
   assign isr_arb = isr;
`endif

   pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_irr_res (
      .req         (irr & ~mask_i),
      .lowest_prio (lowest_prio),
      .valid       (win_valid),
      .id          (win_id)
   );

   pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
      .req         (isr_arb),
      .lowest_prio (lowest_prio),
      .valid       (isr_valid),
      .id          (isr_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack_start = 1'b0;
      ack_end   = 1'b0;
      case (state)
         IDLE: if (inta_i) begin
            state_nxt = ACK1;
            ack_start = 1'b1;
         end
         ACK1: if (inta_i) begin
            state_nxt = IDLE;
            ack_end   = 1'b1;
         end
      endcase
   end

   // out-of-range specific IDs (non power-of-two NUM_IRQ) are ignored
   always_comb begin
      eoi_hit    = 1'b0;
      eoi_target = isr_id;
      if (eoi_valid_i) begin
         if (eoi_specific_i) begin
            eoi_target = eoi_id_i;
            eoi_hit    = 32'(eoi_id_i) < 32'(NUM_IRQ);
         end else begin
            eoi_hit = isr_valid;
         end
      end
   end

   always_comb begin
      int_nxt = 1'b0;
      if (win_valid) begin
         if (!isr_valid)
            int_nxt = 1'b1;
         else
            int_nxt = prio_rank(32'(win_id), 32'(lowest_prio), NUM_IRQ) <
                      prio_rank(32'(isr_id), 32'(lowest_prio), NUM_IRQ);
      end
   end

   // order matters: EOI first, then AEOI, and the ACK1 set/clear last so it wins
   always_comb begin
      irr_nxt    = level_mode_i ? irq_i : (irr | (irq_i & ~irq_q));
      isr_nxt    = isr;
      lowest_nxt = lowest_prio;
      if (eoi_hit) begin
         isr_nxt[eoi_target] = 1'b0;
         if (eoi_rotate_i || rotate_mode_i) lowest_nxt = eoi_target;
      end
      if (ack_end && aeoi_i && !ack_spur) begin
         isr_nxt[ack_id] = 1'b0;
         if (rotate_mode_i) lowest_nxt = ack_id;
      end
      if (ack_start && win_valid) begin
         isr_nxt[win_id] = 1'b1;
         if (!level_mode_i) irr_nxt[win_id] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q          <= '0;
         irr            <= '0;
         isr            <= '0;
         lowest_prio    <= ID_W'(NUM_IRQ - 1);
         ack_id         <= '0;
         ack_spur       <= 1'b0;
         int_o          <= 1'b0;
         vector_valid_o <= 1'b0;
         vector_o       <= '0;
      end else begin
         irq_q          <= irq_i;
         irr            <= irr_nxt;
         isr            <= isr_nxt;
         lowest_prio    <= lowest_nxt;
         int_o          <= int_nxt;
         vector_valid_o <= ack_end;
         if (ack_start) begin
            ack_id   <= win_valid ? win_id : ID_W'(spurious_id(NUM_IRQ));
            ack_spur <= !win_valid;
         end
         if (ack_end) vector_o <= ack_id;
      end
   end

   assign irr_o = irr;
   assign isr_o = isr;

endmodule

// File: tb/tb_pic_interrupt_core.sv
// Directed bench for pic_interrupt_core (NUM_IRQ=8 main instance, NUM_IRQ=16 side instance).
// Build with or without PIC_SPECIAL_MASK_EN.
module tb_pic_interrupt_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  irq, mask;
   logic        level_mode, rotate_mode, aeoi, inta;
   logic        eoi_valid, eoi_specific, eoi_rotate;
   logic [2:0]  eoi_id;
   logic        int_out, vv;
   logic [2:0]  vector;
   logic [7:0]  irr, isr;

   logic [15:0] irq16, mask16;
   logic        inta16, eoi_valid16;
   logic [3:0]  eoi_id16;
   logic        int16, vv16;
   logic [3:0]  vec16;
   logic [15:0] irr16, isr16;

`ifdef PIC_SPECIAL_MASK_EN
   logic        smm, smm16;
   localparam logic SMM_BUILD = 1'b1;
`else
   localparam logic SMM_BUILD = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pic_interrupt_core #(.NUM_IRQ(8)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq),
      .mask_i         (mask),
      .level_mode_i   (level_mode),
      .rotate_mode_i  (rotate_mode),
      .aeoi_i         (aeoi),
      .inta_i         (inta),
      .eoi_valid_i    (eoi_valid),
      .eoi_specific_i (eoi_specific),
      .eoi_rotate_i   (eoi_rotate),
      .eoi_id_i       (eoi_id),
`ifdef PIC_SPECIAL_MASK_EN
      .smm_i          (smm),
`endif
      .int_o          (int_out),
      .vector_valid_o (vv),
      .vector_o       (vector),
      .irr_o          (irr),
      .isr_o          (isr)
   );

   pic_interrupt_core #(.NUM_IRQ(16)) u_dut16 (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq16),
      .mask_i         (mask16),
      .level_mode_i   (1'b0),
      .rotate_mode_i  (1'b0),
      .aeoi_i         (1'b0),
      .inta_i         (inta16),
      .eoi_valid_i    (eoi_valid16),
      .eoi_specific_i (1'b0),
      .eoi_rotate_i   (1'b0),
      .eoi_id_i       (eoi_id16),
`ifdef PIC_SPECIAL_MASK_EN
      .smm_i          (smm16),
`endif
      .int_o          (int16),
      .vector_valid_o (vv16),
      .vector_o       (vec16),
      .irr_o          (irr16),
      .isr_o          (isr16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      irq = v;
      tick();
      irq = '0;
      tick();
   endtask

   task automatic inta_pulse();
      inta = 1'b1;
      tick();
      inta = 1'b0;
   endtask

   task automatic eoi(input logic spec, input logic [2:0] id, input logic rot);
      eoi_valid    = 1'b1;
      eoi_specific = spec;
      eoi_id       = id;
      eoi_rotate   = rot;
      tick();
      eoi_valid    = 1'b0;
      eoi_specific = 1'b0;
      eoi_id       = '0;
      eoi_rotate   = 1'b0;
   endtask

   // two INTA pulses, then check the vector pulse
   task automatic ack_expect(input string tag, input logic [2:0] exp_vec);
      inta_pulse();
      inta_pulse();
      check_val({tag, "_vv"}, 32'(vv), 32'h1);
      check_val({tag, "_vec"}, 32'(vector), 32'(exp_vec));
   endtask

   initial begin
      rst_n = 1'b0;
      irq = '0; mask = '0; level_mode = 1'b0; rotate_mode = 1'b0; aeoi = 1'b0; inta = 1'b0;
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_id = '0;
      irq16 = '0; mask16 = '0; inta16 = 1'b0; eoi_valid16 = 1'b0; eoi_id16 = '0;
`ifdef PIC_SPECIAL_MASK_EN
      smm = 1'b0; smm16 = 1'b0;
`endif
      tick();
      tick();
      check_val("rst_irr", 32'(irr), 32'h0);
      check_val("rst_isr", 32'(isr), 32'h0);
      check_val("rst_int", 32'(int_out), 32'h0);
      check_val("rst_vv", 32'(vv), 32'h0);
      check_val("rst_vec", 32'(vector), 32'h0);
      rst_n = 1'b1;
      tick();

      // edge mode, fully nested
      pulse_irq(8'h08);
      pulse_irq(8'h20);
      check_val("nest_irr", 32'(irr), 32'h28);
      check_val("nest_int", 32'(int_out), 32'h1);
      ack_expect("nest_ack3", 3'd3);
      check_val("nest_isr", 32'(isr), 32'h08);
      check_val("nest_irr2", 32'(irr), 32'h20);
      tick();
      check_val("nest_vv_drop", 32'(vv), 32'h0);
      tick();
      check_val("nest_int_blocked", 32'(int_out), 32'h0);
      eoi(1'b0, 3'd0, 1'b0);
      check_val("nest_eoi_isr", 32'(isr), 32'h0);
      tick();
      check_val("nest_int_after_eoi", 32'(int_out), 32'h1);
      ack_expect("nest_ack5", 3'd5);
      check_val("nest_isr5", 32'(isr), 32'h20);

      // preemption by a higher-priority line
      pulse_irq(8'h04);
      check_val("pre_int", 32'(int_out), 32'h1);
      ack_expect("pre_ack2", 3'd2);
      check_val("pre_isr", 32'(isr), 32'h24);
      eoi(1'b0, 3'd0, 1'b0);
      check_val("pre_eoi_ns", 32'(isr), 32'h20);
      eoi(1'b0, 3'd0, 1'b0);
      check_val("pre_eoi_ns2", 32'(isr), 32'h0);

      // masked line latches but does not interrupt
      mask = 8'h08;
      pulse_irq(8'h08);
      check_val("mask_irr", 32'(irr), 32'h08);
      check_val("mask_int", 32'(int_out), 32'h0);
      mask = '0;
      tick();
      check_val("unmask_int", 32'(int_out), 32'h1);
      ack_expect("mask_ack3", 3'd3);
      eoi(1'b1, 3'd3, 1'b0);
      check_val("spec_eoi_isr", 32'(isr), 32'h0);

      // automatic rotation
      rotate_mode = 1'b1;
      pulse_irq(8'h11);
      ack_expect("rot_ack0", 3'd0);
      eoi(1'b0, 3'd0, 1'b0);
      pulse_irq(8'h01);
      check_val("rot_irr", 32'(irr), 32'h11);
      ack_expect("rot_ack4", 3'd4);
      check_val("rot_irr2", 32'(irr), 32'h01);
      eoi(1'b0, 3'd0, 1'b0);
      ack_expect("rot_ack0b", 3'd0);
      eoi(1'b0, 3'd0, 1'b0);
      rotate_mode = 1'b0;
      check_val("rot_isr", 32'(isr), 32'h0);

      // new edge on the same cycle as the INTA clear is lost
      pulse_irq(8'h02);
      irq  = 8'h02;
      inta = 1'b1;
      tick();
      irq  = '0;
      inta = 1'b0;
      check_val("race_irr", 32'(irr), 32'h0);
      check_val("race_isr", 32'(isr), 32'h02);
      inta_pulse();
      check_val("race_vec", 32'(vector), 32'h1);
      eoi(1'b0, 3'd0, 1'b0);

      // spurious acknowledge
      ack_expect("spur", 3'd7);
      check_val("spur_isr", 32'(isr), 32'h0);
      check_val("spur_irr", 32'(irr), 32'h0);

      // AEOI with a held level request
      level_mode = 1'b1;
      aeoi       = 1'b1;
      irq        = 8'h40;
      tick();
      tick();
      check_val("aeoi_int", 32'(int_out), 32'h1);
      ack_expect("aeoi_ack6", 3'd6);
      check_val("aeoi_isr", 32'(isr), 32'h0);
      check_val("aeoi_int_gap", 32'(int_out), 32'h0);
      tick();
      check_val("aeoi_int_again", 32'(int_out), 32'h1);
      irq = '0;
      tick();
      level_mode = 1'b0;
      aeoi       = 1'b0;
      tick();
      tick();
      check_val("aeoi_irr_clear", 32'(irr), 32'h0);
      check_val("aeoi_int_clear", 32'(int_out), 32'h0);

      // reset between the two INTA pulses
      pulse_irq(8'h08);
      inta_pulse();
      check_val("mid_isr", 32'(isr), 32'h08);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_isr", 32'(isr), 32'h0);
      check_val("mid_rst_irr", 32'(irr), 32'h0);
      check_val("mid_rst_int", 32'(int_out), 32'h0);
      tick();
      check_val("mid_rst_vv", 32'(vv), 32'h0);
      rst_n = 1'b1;
      tick();
      inta_pulse();
      check_val("mid_no_vv", 32'(vv), 32'h0);
      inta_pulse();
      check_val("mid_new_vv", 32'(vv), 32'h1);
      check_val("mid_new_vec", 32'(vector), 32'h7);

      // masked in-service level: blocks line 6 unless special mask mode is on
      pulse_irq(8'h20);
      ack_expect("smm_ack5", 3'd5);
      mask = 8'h20;
`ifdef PIC_SPECIAL_MASK_EN
      smm = 1'b1;
`endif
      pulse_irq(8'h40);
      check_val("smm_int", 32'(int_out), 32'(SMM_BUILD));
`ifdef PIC_SPECIAL_MASK_EN
      smm = 1'b0;
      tick();
      check_val("smm_off_int", 32'(int_out), 32'h0);
`endif
      mask = '0;

      // NUM_IRQ = 16 instance
      inta16 = 1'b1; tick(); inta16 = 1'b0;
      inta16 = 1'b1; tick(); inta16 = 1'b0;
      check_val("n16_spur_vv", 32'(vv16), 32'h1);
      check_val("n16_spur_vec", 32'(vec16), 32'hF);
      irq16 = 16'h2000; tick(); irq16 = '0; tick();
      check_val("n16_irr", 32'(irr16), 32'h2000);
      check_val("n16_int", 32'(int16), 32'h1);
      inta16 = 1'b1; tick(); inta16 = 1'b0;
      inta16 = 1'b1; tick(); inta16 = 1'b0;
      check_val("n16_vec", 32'(vec16), 32'hD);
      check_val("n16_isr", 32'(isr16), 32'h2000);
      check_val("n16_irr2", 32'(irr16), 32'h0);
      eoi_valid16 = 1'b1; tick(); eoi_valid16 = 1'b0;
      check_val("n16_eoi", 32'(isr16), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
